// File: rtl/pattern_sequencer.sv
// pattern_sequencer: selects one of NUM_PATTERNS colour buses, switching only at the vsync rising edge.
// Optional TRANSITION_BLANK_EN inserts BLANK_FRAMES blank frames after each switch.
`default_nettype none

module pattern_sequencer #(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAMES_PER_PATTERN = 300,
    parameter int CNT_W              = 10,
    parameter int RGB_W              = 6,
    parameter int BLANK_FRAMES       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vsync,
    input  logic                          paused,
    input  logic                          auto_en,
    input  logic                          next_req,
    input  logic                          prev_req,
    input  logic [NUM_PATTERNS*RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0]              rgb,
    output logic [SEL_W-1:0]              pattern_sel,
    output logic [NUM_PATTERNS-1:0]       next_frame,
    output logic                          pattern_rst,
    output logic [CNT_W-1:0]              frame_count
);

    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_PATTERN - 1);

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t state;
    logic   vsync_q;
    logic   pend_next;
    logic   pend_prev;
    logic   vs_rise;
    logic   show;
    logic   sw_eval;
    logic   do_fwd;
    logic   do_back;
    logic   do_switch;
    logic   set_next;
    logic   set_prev;

    assign vs_rise   = vsync & ~vsync_q;
    assign show      = (state == SHOW);
    assign sw_eval   = vs_rise & show;
    // Manual requests outrank auto-advance; the cancel rule keeps both flags from being set together.
    assign do_fwd    = sw_eval & (pend_next |
                       (~pend_prev & auto_en & ~paused & (frame_count == LAST_FRAME)));
    assign do_back   = sw_eval & ~pend_next & pend_prev;
    assign do_switch = do_fwd | do_back;

    assign set_next  = (pend_next & ~do_switch) | next_req;
    assign set_prev  = (pend_prev & ~do_switch) | prev_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            pend_next   <= 1'b0;
            pend_prev   <= 1'b0;
            pattern_sel <= '0;
            frame_count <= '0;
            pattern_rst <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (set_next & set_prev) begin
                pend_next <= 1'b0;
                pend_prev <= 1'b0;
            end else begin
                pend_next <= set_next;
                pend_prev <= set_prev;
            end

            pattern_rst <= do_fwd & (pattern_sel == SEL_LAST);

            if (do_fwd) begin
                pattern_sel <= (pattern_sel == SEL_LAST) ? '0 : pattern_sel + 1'b1;
            end else if (do_back) begin
                pattern_sel <= (pattern_sel == '0) ? SEL_LAST : pattern_sel - 1'b1;
            end

            if (do_switch) begin
                frame_count <= '0;
            end else if (sw_eval & auto_en & ~paused & (frame_count != LAST_FRAME)) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

`ifdef TRANSITION_BLANK_EN
    localparam int             BLK_W    = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_FRAMES - 1);

    state_t           state_nxt;
    logic [BLK_W-1:0] blank_cnt;
    logic [BLK_W-1:0] blank_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SHOW;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_cnt_nxt;
        end
    end

    // Blank frames are counted on every vsync edge, even while paused.
    always_comb begin
        state_nxt     = state;
        blank_cnt_nxt = blank_cnt;
        case (state)
            SHOW: begin
                if (do_switch) begin
                    state_nxt     = BLANK;
                    blank_cnt_nxt = '0;
                end
            end
            BLANK: begin
                if (vs_rise) begin
                    if (blank_cnt == BLK_LAST) begin
                        state_nxt     = SHOW;
                        blank_cnt_nxt = '0;
                    end else begin
                        blank_cnt_nxt = blank_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = SHOW;
        endcase
    end
`else
    assign state = SHOW;
`endif

    always_comb begin
        rgb        = '0;
        next_frame = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (pattern_sel == SEL_W'(i)) begin
                if (show) begin
                    rgb = rgb_in[i*RGB_W +: RGB_W];
                end
                next_frame[i] = vs_rise & ~paused & show;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized and directed stimulus checked every cycle against a frame-level reference model.
`default_nettype none

module tb_pattern_sequencer;

    localparam int NP  = 3;
    localparam int FPP = 3;
    localparam int BF  = 2;
`ifdef TRANSITION_BLANK_EN
    localparam int BLANK_EN = 1;
`else
    localparam int BLANK_EN = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         vsync;
    logic         paused;
    logic         auto_en;
    logic         next_req;
    logic         prev_req;
    logic [17:0]  rgb_in = {6'h30, 6'h0C, 6'h03};
    logic [5:0]   rgb;
    logic [1:0]   pattern_sel;
    logic [2:0]   next_frame;
    logic         pattern_rst;
    logic [3:0]   frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    int pat [0:NP-1] = '{'h03, 'h0C, 'h30};
    int m_sel, m_cnt, m_pend, m_blank, m_prst, m_vsq;

    pattern_sequencer #(
        .NUM_PATTERNS      (NP),
        .SEL_W             (2),
        .FRAMES_PER_PATTERN(FPP),
        .CNT_W             (4),
        .RGB_W             (6),
        .BLANK_FRAMES      (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .paused     (paused),
        .auto_en    (auto_en),
        .next_req   (next_req),
        .prev_req   (prev_req),
        .rgb_in     (rgb_in),
        .rgb        (rgb),
        .pattern_sel(pattern_sel),
        .next_frame (next_frame),
        .pattern_rst(pattern_rst),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_cnt = 0; m_pend = 0; m_blank = 0; m_prst = 0; m_vsq = 1;
    endtask

    // Checks outputs mid-cycle, then advances the model by one clock using the current inputs.
    task automatic step();
        bit rise, showing;
        int dir, p;
        @(negedge clk);
        rise    = vsync && (m_vsq == 0);
        showing = (m_blank == 0);
        check("sel",         pattern_sel, m_sel);
        check("frame_count", frame_count, m_cnt);
        check("pattern_rst", pattern_rst, m_prst);
        check("rgb",         rgb, showing ? pat[m_sel] : 0);
        check("next_frame",  next_frame, (rise && !paused && showing) ? (1 << m_sel) : 0);
        dir = 0;
        if (rise && showing) begin
            if (m_pend != 0) dir = m_pend;
            else if (auto_en && !paused && m_cnt == FPP - 1) dir = 1;
        end
        m_prst = (dir == 1 && m_sel == NP - 1) ? 1 : 0;
        p = m_pend;
        if (dir != 0) begin
            m_sel   = (m_sel + dir + NP) % NP;
            m_cnt   = 0;
            p       = 0;
            m_blank = BLANK_EN ? BF : 0;
        end else if (rise && showing && auto_en && !paused && m_cnt < FPP - 1) begin
            m_cnt++;
        end else if (rise && !showing) begin
            m_blank--;
        end
        if (next_req && prev_req) p = 0;
        else if (next_req)        p = (p == -1) ? 0 : 1;
        else if (prev_req)        p = (p == 1) ? 0 : -1;
        m_pend = p;
        m_vsq  = vsync ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic n, input logic p);
        next_req = n;
        prev_req = p;
        step();
        next_req = 1'b0;
        prev_req = 1'b0;
    endtask

    task automatic frame(input int len);
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        repeat (len) step();
    endtask

    initial begin
        rst = 1'b0; vsync = 1'b1; paused = 1'b0; auto_en = 1'b0;
        next_req = 1'b0; prev_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_sel",  pattern_sel, 0);
        check("rst_cnt",  frame_count, 0);
        check("rst_prst", pattern_rst, 0);
        check("rst_rgb",  rgb, 'h03);
        check("rst_nf",   next_frame, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // auto cycle through all patterns and a wrap
        auto_en = 1'b1;
        repeat (10) frame(2);
        // pause holds the counter, then resumes
        paused = 1'b1;
        repeat (5) frame(1);
        paused = 1'b0;
        repeat (3) frame(1);
        // manual steps with auto disabled, including backward wrap
        auto_en = 1'b0;
        req(1'b1, 1'b0); step(); frame(2);
        req(1'b0, 1'b1); frame(2);
        req(1'b0, 1'b1); frame(2);
        req(1'b0, 1'b1); frame(2);
        // cancellation and collapsing of repeated requests
        req(1'b1, 1'b1); frame(2);
        req(1'b1, 1'b0); req(1'b0, 1'b1); frame(2);
        req(1'b1, 1'b0); req(1'b1, 1'b0); frame(2);
        req(1'b1, 1'b0); frame(1); req(1'b1, 1'b0); frame(2); frame(2); frame(2);

        repeat (1500) begin
            vsync    = ($urandom_range(0, 3) != 0);
            paused   = ($urandom_range(0, 7) == 0);
            auto_en  = ($urandom_range(0, 7) != 0);
            next_req = ($urandom_range(0, 15) == 0);
            prev_req = ($urandom_range(0, 19) == 0);
            step();
        end

        // reach sel=2 with a pending next, then reset mid-frame
        vsync = 1'b1; paused = 1'b0; auto_en = 1'b0; next_req = 1'b0; prev_req = 1'b0;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req(1'b1, 1'b0); frame(2); frame(2); frame(2);
        req(1'b1, 1'b0); frame(2); frame(2); frame(2);
        check("pre_arst_sel", pattern_sel, 2);
        req(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_sel",  pattern_sel, 0);
        check("arst_cnt",  frame_count, 0);
        check("arst_rgb",  rgb, 'h03);
        check("arst_prst", pattern_rst, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        frame(2);
        check("arst_no_switch", pattern_sel, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Parametrised pattern sequencer for the VGA demo path. Selects one of NUM_PATTERNS externally generated pattern colour buses and drives the chosen colour to the output.
- Advances patterns automatically every FRAMES_PER_PATTERN frames, or manually through next/prev request pulses.
- All pattern switches are deferred to the frame origin, which is the vsync rising edge.
- Drives per-pattern animation strobes and a generator reset pulse. Sits between the pattern generators and the VGA output stage.

Parameters:
- NUM_PATTERNS, 4, number of pattern inputs (2..16).
- SEL_W, 2, width of the pattern index; must satisfy 2**SEL_W >= NUM_PATTERNS.
- FRAMES_PER_PATTERN, 300, frames shown per pattern in auto mode (>= 1).
- CNT_W, 10, frame counter width; must satisfy 2**CNT_W >= FRAMES_PER_PATTERN.
- RGB_W, 6, colour bus width per pattern.
- BLANK_FRAMES, 8, blank frames inserted per switch; used only with TRANSITION_BLANK_EN.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  asynchronous active-high reset.
- vsync  in  1  VGA vsync, active low; its rising edge marks the frame origin.
- paused  in  1  level; freezes frame counting and animation strobes.
- auto_en  in  1  level; 1 = auto-advance, 0 = hold current pattern.
- next_req  in  1  single-cycle pulse; request the next pattern.
- prev_req  in  1  single-cycle pulse; request the previous pattern.
- rgb_in  in  NUM_PATTERNS*RGB_W  pattern i occupies bits [i*RGB_W +: RGB_W].
- rgb  out  RGB_W  selected colour (combinational mux).
- pattern_sel  out  SEL_W  current pattern index (registered).
- next_frame  out  NUM_PATTERNS  one-hot animation strobe.
- pattern_rst  out  1  one-cycle generator reset pulse (registered).
- frame_count  out  CNT_W  frames shown in the current pattern (registered).

Behaviour:
- Reset values:
  - pattern_sel=0, frame_count=0, pattern_rst=0.
  - vsync_q=1, pend_next=0, pend_prev=0, state=SHOW, blank counter=0.
- Edge detect: vs_rise = vsync & ~vsync_q. vsync_q registers vsync every cycle.
- Request latching (any cycle):
  - next_req sets pend_next; prev_req sets pend_prev.
  - If a request would leave both flags set (simultaneous pulses, or the opposite one already pending), both flags clear. Net effect: no switch.
  - Repeated requests of the same direction before vs_rise collapse to a single step.
- Switch decision, evaluated only on a vs_rise cycle in state SHOW:
  - pend_next -> forward step.
  - else pend_prev -> backward step.
  - else if auto_en & ~paused & frame_count==FRAMES_PER_PATTERN-1 -> forward step.
  - Manual requests take priority over auto, and are honoured even when paused or auto_en=0.
  - A switch clears both pending flags and sets frame_count to 0.
- Step arithmetic:
  - Forward: NUM_PATTERNS-1 wraps to 0.
  - Backward: 0 wraps to NUM_PATTERNS-1.
  - pattern_sel never holds a value >= NUM_PATTERNS.
- No switch on a vs_rise cycle:
  - frame_count increments if auto_en & ~paused, else holds.
  - frame_count saturates at FRAMES_PER_PATTERN-1 when auto_en=0 (not reachable in practice, since it only counts while auto_en=1).
- pattern_rst: asserted for exactly one cycle, the cycle after any forward wrap (NUM_PATTERNS-1 -> 0), whether auto or manual. Backward wraps do not pulse it.
- next_frame[i] = vs_rise & ~paused & (pattern_sel==i) & (state==SHOW).
  - Uses pattern_sel before the update; latency 0 from vs_rise.
- rgb = slice of rgb_in at pattern_sel when state==SHOW, else 0.
- Reset mid-frame: all state returns to reset values immediately; pending requests are discarded.

Optional Feature:
- Macro: TRANSITION_BLANK_EN.
- Enabled: adds state BLANK.
  - Every switch enters BLANK with blank counter=0.
  - In BLANK: rgb=0, next_frame=0, frame_count held at 0.
  - Blank counter increments on each vs_rise regardless of paused. On the vs_rise where it equals BLANK_FRAMES-1, state returns to SHOW.
  - Requests arriving during BLANK stay latched (cancel rule still applies) and are evaluated at the first vs_rise in SHOW.
- Disabled: state is constant SHOW; no blank counter is synthesised.

Test Plan:
All scenarios use NUM_PATTERNS=3, FRAMES_PER_PATTERN=3, RGB_W=6, rgb_in={6'h30,6'h0C,6'h03}.
- Auto cycle, auto_en=1, 9 vs_rise:
  - pattern_sel sequence 0,0,0,1,1,1,2,2,2, then 0 on the 9th.
  - pattern_rst pulses once, the cycle after 2->0.
  - rgb follows 03->0C->30->03.
- Pause: paused=1 for 5 vs_rise at frame_count=1:
  - frame_count stays 1, pattern_sel stays 0, next_frame=0.
  - After release, the switch occurs on the 2nd vs_rise.
- Manual deferral: auto_en=0, next_req mid-frame:
  - pattern_sel unchanged until the next vs_rise, then 1 with frame_count=0.
  - prev_req at sel 0 -> 2, with no pattern_rst.
- Cancel: next_req and prev_req in the same cycle, or next then prev before vs_rise -> pattern_sel unchanged at vs_rise.
- Async reset asserted mid-frame, with pend_next set and sel=2:
  - Outputs return to sel=0, frame_count=0, rgb=03 without a clock edge.
  - No switch at the next vs_rise.
- TRANSITION_BLANK_EN, BLANK_FRAMES=2: next_req then vs_rise:
  - sel=1, and rgb=0 for 2 frames.
  - next_frame is silent during those frames, then rgb=0C.
  - A next_req issued during BLANK is applied at the first vs_rise after BLANK.
